conv_line_buffer: RTL
=====================

Name: conv_line_buffer

Overview:
- Upstream feeder for the SlidingWindow convolution stage.
- Accepts a raster-order pixel stream, one pixel per cycle, for a fixed-size image.
- Buffers KERNEL_HEIGHT-1 full image lines plus a KERNEL_HEIGHT x KERNEL_WIDTH window register.
- Emits one packed window per valid (unpadded) kernel position, ready for the SlidingWindow data input.

Parameters:
- KERNEL_WIDTH, 3, window columns.
- KERNEL_HEIGHT, 3, window rows.
- DATA_WIDTH, 16, pixel width in bits.
- IMG_WIDTH, 32, pixels per line; must be >= KERNEL_WIDTH.
- IMG_HEIGHT, 32, lines per frame; must be >= KERNEL_HEIGHT.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, synchronous, active-high reset.
- pixel_in, input, DATA_WIDTH, raster pixel.
- pixel_valid, input, 1, pixel_in is valid.
- pixel_ready, output, 1, block accepts pixel this cycle.
- window_out, output, KERNEL_WIDTH*KERNEL_HEIGHT*DATA_WIDTH, packed window.
- window_valid, output, 1, window_out holds a valid window.
- window_ready, input, 1, downstream accepts the window.

Behaviour:
- Reset values: window_valid=0, window_out=0, col/row counters=0, window register=0. Line-buffer contents are don't-care.
- Accept: a pixel is accepted when pixel_valid && pixel_ready.
- pixel_ready = !window_valid || window_ready. This is a combinational pass-through with no skid buffer.
- Counters: col counts 0..IMG_WIDTH-1 and row counts 0..IMG_HEIGHT-1, each advancing only on accept.
  - col wraps to 0 and increments row.
  - At (IMG_HEIGHT-1, IMG_WIDTH-1), both wrap to 0 and the next pixel starts a new frame. There are no gaps between frames.
- Line buffers: KERNEL_HEIGHT-1 buffers, each IMG_WIDTH deep, addressed by col. On accept at column c:
  - The new window column is {line[KH-2][c], ..., line[0][c], pixel_in}, oldest row first.
  - line[0][c] <= pixel_in; line[k][c] <= line[k-1][c].
  - The window register shifts left by one column and the new column enters at col KERNEL_WIDTH-1.
- Packing: element (r,c), with r=0 the top/oldest row and c=0 the leftmost/oldest column, occupies window_out[(r*KERNEL_WIDTH+c)*DATA_WIDTH +: DATA_WIDTH]. Element (0,0) is at the LSBs.
- Valid window:
  - Produced on an accept where row >= KERNEL_HEIGHT-1 and col >= KERNEL_WIDTH-1, with row/col taken before the increment.
  - window_out and window_valid are registered, so a window appears the cycle after the completing pixel is accepted.
  - Stale columns left over from the previous line are never emitted.
- Hold: while window_valid && !window_ready, window_out is held stable and pixel_ready=0.
  - On window_ready, the window is consumed. If no new valid window is produced in the same cycle, window_valid drops next cycle.
  - A simultaneous consume and accept that completes a new window keeps window_valid=1 with the new data.
- Throughput: windows per frame = (IMG_HEIGHT-KERNEL_HEIGHT+1)*(IMG_WIDTH-KERNEL_WIDTH+1). With window_ready tied high, the block sustains 1 pixel/cycle.
- Reset mid-frame: counters and outputs clear immediately and the next accepted pixel is treated as (0,0). Partial-frame data is never emitted.

Optional Feature:
- Macro: CONV_LINE_BUFFER_LAST_EN.
- With the macro defined:
  - Adds output port window_last (1 bit), registered alongside window_valid.
  - window_last=1 only on the final window of a frame, i.e. the window completed by pixel (IMG_HEIGHT-1, IMG_WIDTH-1).
  - window_last resets to 0 and is held together with window_out under backpressure.
- Without the macro: the port and its logic do not exist. All other behaviour is identical.

Test Plan (IMG_WIDTH=5, IMG_HEIGHT=4, 3x3 kernel, DATA_WIDTH=16, window_ready=1 unless stated):
- Stream pixels 0..19, valid every cycle -> first window_valid is one cycle after pixel 12 is accepted, with rows {0,1,2},{5,6,7},{10,11,12}. Exactly 6 windows are emitted.
- Same frame -> last window is {7,8,9},{12,13,14},{17,18,19}. With CONV_LINE_BUFFER_LAST_EN, window_last=1 on this window only.
- Backpressure: drop window_ready for 4 cycles after the first window -> pixel_ready=0 and window_out stays {0,1,2,5,6,7,10,11,12} throughout. No pixel is lost, and all 6 windows are still seen in order.
- Random pixel_valid gaps (~50% duty) over pixels 0..19 -> the window sequence is identical to the gap-free run.
- Two back-to-back frames, values 0..19 then 100..119 -> 12 windows; the second frame's windows equal the first frame's plus 100 elementwise.
- Reset asserted after 7 pixels, then frame 0..19 -> no window before pixel 12 of the new frame, and exactly 6 correct windows.

Source files
------------

// File: rtl/conv_line_buffer.sv
// Raster-stream line buffer that emits a packed KERNEL_HEIGHT x KERNEL_WIDTH window per unpadded position.
// Optional window_last output (final window of a frame) enabled by defining CONV_LINE_BUFFER_LAST_EN.
module conv_line_buffer #(
   parameter int KERNEL_WIDTH  = 3,
   parameter int KERNEL_HEIGHT = 3,
   parameter int DATA_WIDTH    = 16,
   parameter int IMG_WIDTH     = 32,
   parameter int IMG_HEIGHT    = 32
) (
   input  logic                                             clk,
   input  logic                                             reset,
   input  logic [DATA_WIDTH-1:0]                            pixel_in,
   input  logic                                             pixel_valid,
   output logic                                             pixel_ready,
   output logic [KERNEL_WIDTH*KERNEL_HEIGHT*DATA_WIDTH-1:0] window_out,
   output logic                                             window_valid,
`ifdef CONV_LINE_BUFFER_LAST_EN
   output logic                                             window_last,
`endif
   input  logic                                             window_ready
);

   localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
   localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

   logic [COL_W-1:0] col_reg;
   logic [ROW_W-1:0] row_reg;
   logic             window_valid_reg;
   logic [KERNEL_WIDTH*KERNEL_HEIGHT*DATA_WIDTH-1:0] window_out_reg;

   // Packed so that element (r,c) lands at ((r*KERNEL_WIDTH)+c)*DATA_WIDTH.
   logic [KERNEL_HEIGHT-1:0][KERNEL_WIDTH-1:0][DATA_WIDTH-1:0] win_reg;
   logic [KERNEL_HEIGHT-1:0][KERNEL_WIDTH-1:0][DATA_WIDTH-1:0] win_next;
   logic [KERNEL_HEIGHT-1:0][DATA_WIDTH-1:0]                   new_col;
   logic [KERNEL_HEIGHT-2:0][DATA_WIDTH-1:0]                   line_tap;

   logic accept;
   logic col_last;
   logic row_last;
   logic in_window;
   logic win_done;

   assign pixel_ready = !window_valid_reg || window_ready;
   assign accept      = pixel_valid && pixel_ready;
   assign col_last    = (col_reg == COL_W'(IMG_WIDTH - 1));
   assign row_last    = (row_reg == ROW_W'(IMG_HEIGHT - 1));
   assign in_window   = (row_reg >= ROW_W'(KERNEL_HEIGHT - 1)) &&
                        (col_reg >= COL_W'(KERNEL_WIDTH - 1));
   assign win_done    = accept && in_window;

   genvar gi, gj;

   // Line k holds the row that is k+1 lines older than the incoming one.
   for (gi = 0; gi < KERNEL_HEIGHT - 1; gi++) begin : g_line
      logic [DATA_WIDTH-1:0] mem [IMG_WIDTH];

      assign line_tap[gi] = mem[col_reg];

      if (gi == 0) begin : g_first
         always_ff @(posedge clk) begin
            if (accept) begin
               mem[col_reg] <= pixel_in;
            end
         end
      end else begin : g_chain
         always_ff @(posedge clk) begin
            if (accept) begin
               mem[col_reg] <= line_tap[gi-1];
            end
         end
      end
   end

   assign new_col[KERNEL_HEIGHT-1] = pixel_in;
   for (gi = 0; gi < KERNEL_HEIGHT - 1; gi++) begin : g_new_col
      assign new_col[gi] = line_tap[KERNEL_HEIGHT-2-gi];
   end

   for (gi = 0; gi < KERNEL_HEIGHT; gi++) begin : g_row
      for (gj = 0; gj < KERNEL_WIDTH; gj++) begin : g_col
         if (gj == KERNEL_WIDTH - 1) begin : g_enter
            assign win_next[gi][gj] = new_col[gi];
         end else begin : g_shift
            assign win_next[gi][gj] = win_reg[gi][gj+1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         col_reg          <= '0;
         row_reg          <= '0;
         win_reg          <= '0;
         window_out_reg   <= '0;
         window_valid_reg <= 1'b0;
      end else begin
         if (accept) begin
            win_reg <= win_next;
            if (col_last) begin
               col_reg <= '0;
               row_reg <= row_last ? '0 : row_reg + ROW_W'(1);
            end else begin
               col_reg <= col_reg + COL_W'(1);
            end
         end
         // A window completing in the same cycle as a consume replaces the old one.
         if (win_done) begin
            window_out_reg   <= win_next;
            window_valid_reg <= 1'b1;
         end else if (window_ready) begin
            window_valid_reg <= 1'b0;
         end
      end
   end

   assign window_out   = window_out_reg;
   assign window_valid = window_valid_reg;

`ifdef CONV_LINE_BUFFER_LAST_EN
   logic window_last_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         window_last_reg <= 1'b0;
      end else if (win_done) begin
         window_last_reg <= row_last && col_last;
      end
   end

   assign window_last = window_last_reg;
`endif

endmodule
